branch_exec_unit: RTL and testbench

//  Branch execution stage. Takes one ready branch/jump per cycle from the branch reservation station, resolves it, and drives the Branch CDB.
//  CDB consumers are the RSs, the LSB and the ROB. Also resolves direction, next-PC and link value for the ROB.

---
 rtl/branch_exec_unit_pkg.sv | 42 ++++
 rtl/branch_exec_unit_bht.sv | 39 +++
 rtl/branch_exec_unit.sv | 145 ++++++++++++++
 tb/tb_branch_exec_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_exec_unit_pkg.sv
// Shared CPU definitions for the branch execution unit and its BHT.
// Holds the opcode encodings, the bus typedefs and valid/null constants.
// It also holds the BHT index width and the 2-bit saturating counter update.
// Contents: OP_* opcode constants, op_bus_t/tag_bus_t/data_bus_t,
//   VALID/INVALID/NULL_DATA, BHT_INIT, bht_next().
package branch_exec_unit_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int TAG_W_DEF     = 4;
  localparam int OP_W_DEF      = 6;
  localparam int BHT_IDX_W_DEF = 8;

  typedef logic [OP_W_DEF-1:0]   op_bus_t;
  typedef logic [TAG_W_DEF-1:0]  tag_bus_t;
  typedef logic [DATA_W_DEF-1:0] data_bus_t;

  localparam op_bus_t OP_BEQ  = 6'd1;
  localparam op_bus_t OP_BNE  = 6'd2;
  localparam op_bus_t OP_BLT  = 6'd3;
  localparam op_bus_t OP_BGE  = 6'd4;
  localparam op_bus_t OP_BLTU = 6'd5;
  localparam op_bus_t OP_BGEU = 6'd6;
  localparam op_bus_t OP_JAL  = 6'd7;
  localparam op_bus_t OP_JALR = 6'd8;

  localparam logic      VALID     = 1'b1;
  localparam logic      INVALID   = 1'b0;
  localparam data_bus_t NULL_DATA = '0;

  // Reset value of every counter: weakly not-taken.
  localparam logic [1:0] BHT_INIT = 2'b01;

  // Two-bit saturating counter step.
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_exec_unit_bht.sv
// Branch history table: an array of 2-bit saturating counters.
// It has one combinational read port for fetch and one registered update port.
// A read and an update of the same index in one cycle return the pre-update value.
// Ports:
//   clk, rst     clock, synchronous active-high reset (all entries -> BHT_INIT)
//   i_upd_en     update strobe (already qualified by rdy/clear/conditional)
//   i_upd_idx    index to update
//   i_upd_taken  resolved direction
//   i_rd_idx     fetch lookup index
//   o_rd_taken   prediction (counter MSB)
module branch_bht
  import branch_exec_unit_pkg::*;
#(
  parameter int IDX_W = BHT_IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken
);

  localparam int NUM_ENT = 1 << IDX_W;

  logic [1:0] r_ctr [NUM_ENT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) r_ctr[i] <= BHT_INIT;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= bht_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

  assign o_rd_taken = r_ctr[i_rd_idx][1];

endmodule

// File: rtl/branch_exec_unit.sv
// Branch execution stage. It resolves one branch or jump per cycle from the branch RS.
// It broadcasts the result on the Branch CDB with one cycle of latency.
// It also updates the BHT that fetch reads combinationally.
// Optional build macro: BRANCH_STATS_EN adds the stat_branches/stat_taken counters.
// Ports:
//   clk, rst, rdy, clear        clock, sync active-high reset, global enable, flush
//   in_valid, in_op, in_reg1, in_reg2, in_imm, in_pc, in_dest_tag   issue from RS
//   cdb_valid, cdb_tag, cdb_data, br_taken, br_target               registered result
//   stat_branches, stat_taken   (BRANCH_STATS_EN only) conditional / taken counts
//   fetch_pc, fetch_pred_taken  BHT lookup for fetch
module branch_exec_unit
  import branch_exec_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int BHT_IDX_W = BHT_IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_reg1,
  input  logic [DATA_W-1:0] in_reg2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_dest_tag,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
`ifdef BRANCH_STATS_EN
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_taken,
`endif
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              fetch_pred_taken
);

  logic              w_is_cond;
  logic              w_taken;
  logic [DATA_W-1:0] w_target;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_link;
  logic [DATA_W-1:0] w_pc_rel;
  logic [DATA_W-1:0] w_jalr;
  logic              w_accept;
  logic              w_unused_fetch_bits;

  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic              r_br_taken;
  logic [DATA_W-1:0] r_br_target;

  assign w_link   = in_pc + DATA_W'(4);
  assign w_pc_rel = in_pc + in_imm;
  assign w_jalr   = (in_reg1 + in_imm) & ~DATA_W'(1);
  assign w_accept = rdy & in_valid & ~clear;

  // Unknown opcodes fall through the defaults: not taken, pc+4, no link.
  // They still produce a valid CDB beat so the ROB entry retires.
  always_comb begin
    w_is_cond = 1'b0;
    w_taken   = 1'b0;
    w_data    = NULL_DATA;
    case (in_op)
      OP_BEQ:  begin w_is_cond = 1'b1; w_taken = (in_reg1 == in_reg2); end
      OP_BNE:  begin w_is_cond = 1'b1; w_taken = (in_reg1 != in_reg2); end
      OP_BLT:  begin w_is_cond = 1'b1; w_taken = ($signed(in_reg1) <  $signed(in_reg2)); end
      OP_BGE:  begin w_is_cond = 1'b1; w_taken = ($signed(in_reg1) >= $signed(in_reg2)); end
      OP_BLTU: begin w_is_cond = 1'b1; w_taken = (in_reg1 <  in_reg2); end
      OP_BGEU: begin w_is_cond = 1'b1; w_taken = (in_reg1 >= in_reg2); end
      OP_JAL, OP_JALR: begin w_taken = 1'b1; w_data = w_link; end
      default: ;
    endcase
    w_target = w_link;
    if (w_taken) w_target = (in_op == OP_JALR) ? w_jalr : w_pc_rel;
  end

  // rdy low freezes everything, including the effect of clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cdb_valid <= INVALID;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else if (rdy) begin
      if (in_valid && !clear) begin
        r_cdb_valid <= VALID;
        r_cdb_tag   <= in_dest_tag;
        r_cdb_data  <= w_data;
        r_br_taken  <= w_taken;
        r_br_target <= w_target;
      end else begin
        r_cdb_valid <= INVALID;
        r_cdb_tag   <= '0;
        r_cdb_data  <= '0;
        r_br_taken  <= 1'b0;
        r_br_target <= '0;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign br_taken  = r_br_taken;
  assign br_target = r_br_target;

  branch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_upd_en    (w_accept & w_is_cond),
    .i_upd_idx   (in_pc[BHT_IDX_W+1:2]),
    .i_upd_taken (w_taken),
    .i_rd_idx    (fetch_pc[BHT_IDX_W+1:2]),
    .o_rd_taken  (fetch_pred_taken)
  );

  assign w_unused_fetch_bits = ^{fetch_pc[DATA_W-1:BHT_IDX_W+2], fetch_pc[1:0]};

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches <= '0;
      r_stat_taken    <= '0;
    end else if (w_accept && w_is_cond) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_taken) r_stat_taken <= r_stat_taken + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
`endif

endmodule

// File: tb/tb_branch_exec_unit.sv
module tb_branch_exec_unit;
  import branch_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, in_valid;
  logic [5:0]  in_op;
  logic [31:0] in_reg1, in_reg2, in_imm, in_pc, fetch_pc;
  logic [3:0]  in_dest_tag;
  logic        cdb_valid, br_taken, fetch_pred_taken;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data, br_target;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  logic [69:0] obs;
  assign obs = {cdb_valid, cdb_tag, cdb_data, br_taken, br_target};

  int errors = 0;
  int checks = 0;

  // Reference state: per-index counter values and stat counts.
  int          mbht[256];
  int unsigned m_br, m_tk;

  typedef struct packed {
    logic        cond;
    logic        taken;
    logic [31:0] target;
    logic [31:0] data;
  } exp_t;

  always #5 clk = ~clk;

  branch_exec_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_imm(in_imm), .in_pc(in_pc), .in_dest_tag(in_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .br_taken(br_taken), .br_target(br_target),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken),
`endif
    .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken)
  );

  function automatic longint as_signed(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sh1_0000_0000 : longint'(v);
  endfunction

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] r1, r2, imm, pc);
    exp_t   e;
    longint m;
    m = 64'sh1_0000_0000;
    e = '0;
    e.cond = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    case (op)
      OP_BEQ:  e.taken = (longint'(r1) == longint'(r2));
      OP_BNE:  e.taken = (longint'(r1) != longint'(r2));
      OP_BLT:  e.taken = as_signed(r1) <  as_signed(r2);
      OP_BGE:  e.taken = as_signed(r1) >= as_signed(r2);
      OP_BLTU: e.taken = longint'(r1) <  longint'(r2);
      OP_BGEU: e.taken = longint'(r1) >= longint'(r2);
      OP_JAL, OP_JALR: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    if (!e.taken)        e.target = 32'((longint'(pc) + 4) % m);
    else if (op == OP_JALR) e.target = 32'((((longint'(r1) + longint'(imm)) % m) / 2) * 2);
    else                 e.target = 32'((longint'(pc) + longint'(imm)) % m);
    if (op == OP_JAL || op == OP_JALR) e.data = 32'((longint'(pc) + 4) % m);
    return e;
  endfunction

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % 256);
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
    return mbht[bidx(pc)] >= 2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mbht[i] = 1;
    m_br = 0;
    m_tk = 0;
  endfunction

  function automatic void model_commit(input logic [5:0] op, input logic [31:0] r1, r2, imm, pc);
    exp_t e;
    int   i;
    e = model(op, r1, r2, imm, pc);
    i = bidx(pc);
    if (e.cond) begin
      m_br++;
      if (e.taken) begin
        m_tk++;
        if (mbht[i] < 3) mbht[i]++;
      end else if (mbht[i] > 0) mbht[i]--;
    end
  endfunction

  // Drives one issue; the reference model commits only if the DUT will accept it.
  task automatic drive(input logic [5:0] op, input logic [31:0] r1, r2, imm, pc, input logic [3:0] tag);
    in_valid = 1'b1; in_op = op; in_reg1 = r1; in_reg2 = r2;
    in_imm = imm; in_pc = pc; in_dest_tag = tag;
    if (!rst && rdy && !clear) model_commit(op, r1, r2, imm, pc);
  endtask

  task automatic test_reset();
    logic [69:0] want;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_op = '0; in_reg1 = '0; in_reg2 = '0; in_imm = '0; in_pc = '0; in_dest_tag = '0;
    fetch_pc = 32'h100;
    repeat (2) @(negedge clk);
    drive(OP_JAL, 0, 0, 32'h40, 32'h10, 4'h9);
    @(negedge clk);
    model_reset();
    want = '0;
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, want); end
    checks++;
    if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", fetch_pred_taken); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", cdb_valid); end
  endtask

  task automatic test_directed();
    logic [69:0] want;
    drive(OP_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 4'h3);
    @(negedge clk);
    want = {1'b1, 4'h3, 32'h0, 1'b1, 32'h120};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL beq_taken: got %h want %h", obs, want); end
    drive(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h180, 4'h5);
    @(negedge clk);
    want = {1'b1, 4'h5, 32'h0, 1'b1, 32'h1C0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL blt_signed: got %h want %h", obs, want); end
    drive(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h180, 4'h6);
    @(negedge clk);
    want = {1'b1, 4'h6, 32'h0, 1'b0, 32'h184};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL bltu_unsigned: got %h want %h", obs, want); end
    drive(OP_JALR, 32'h1003, 32'h0, 32'd4, 32'h200, 4'h7);
    @(negedge clk);
    want = {1'b1, 4'h7, 32'h204, 1'b1, 32'h1006};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL jalr: got %h want %h", obs, want); end
    drive(OP_JAL, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h8, 4'h2);
    @(negedge clk);
    want = {1'b1, 4'h2, 32'hC, 1'b1, 32'hFFFF_FFF8};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL jal_wrap: got %h want %h", obs, want); end
    drive(6'h3F, 32'h1, 32'h1, 32'h80, 32'hFFFF_FFFC, 4'hB);
    @(negedge clk);
    want = {1'b1, 4'hB, 32'h0, 1'b0, 32'h0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL unknown_op: got %h want %h", obs, want); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("FAIL one_cycle_valid: got %b want 0", cdb_valid); end
  endtask

  task automatic test_bht();
    logic exp_tk[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_nt[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    fetch_pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      drive(OP_BNE, 32'd1, 32'd2, 32'h8, 32'h300, 4'h1);
      #1;
      checks++;
      if (fetch_pred_taken !== exp_tk[i])
        begin errors++; $display("FAIL bht_taken_%0d: got %b want %b", i, fetch_pred_taken, exp_tk[i]); end
      @(negedge clk);
    end
    in_valid = 1'b0; #1;
    checks++;
    if (fetch_pred_taken !== 1'b1) begin errors++; $display("FAIL bht_sat_high: got %b want 1", fetch_pred_taken); end
    for (int i = 0; i < 4; i++) begin
      drive(OP_BNE, 32'd7, 32'd7, 32'h8, 32'h300, 4'h1);
      #1;
      checks++;
      if (fetch_pred_taken !== exp_nt[i])
        begin errors++; $display("FAIL bht_not_taken_%0d: got %b want %b", i, fetch_pred_taken, exp_nt[i]); end
      @(negedge clk);
    end
    drive(OP_BNE, 32'd1, 32'd2, 32'h8, 32'h300, 4'h1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++;
    if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL bht_sat_low: got %b want 0", fetch_pred_taken); end
  endtask

  task automatic test_clear_reset();
    int bad;
    clear = 1'b1; fetch_pc = 32'h400;
    drive(OP_BEQ, 32'd9, 32'd9, 32'h10, 32'h400, 4'h6);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (obs !== 70'd0) begin errors++; $display("FAIL clear_outputs: got %h want 0", obs); end
    checks++;
    if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL clear_bht_kept: got %b want 0", fetch_pred_taken); end
    fetch_pc = 32'h500;
    drive(OP_BEQ, 32'd1, 32'd1, 32'h10, 32'h500, 4'h4);
    @(negedge clk);
    drive(OP_BEQ, 32'd1, 32'd1, 32'h10, 32'h500, 4'h4);
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++;
    if (fetch_pred_taken !== model_pred(32'h500))
      begin errors++; $display("FAIL pre_rst_pred: got %b want %b", fetch_pred_taken, model_pred(32'h500)); end
    rst = 1'b1;
    drive(OP_JAL, 32'h0, 32'h0, 32'h40, 32'h600, 4'h8);
    @(negedge clk);
    model_reset();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (obs !== 70'd0) begin errors++; $display("FAIL midstream_rst: got %h want 0", obs); end
    bad = 0;
    for (int p = 0; p < 256; p++) begin
      fetch_pc = 32'(p * 4); #1;
      if (fetch_pred_taken !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_bht_all: got %0d predicted-taken entries want 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_rdy_hold();
    logic [69:0] hold;
    drive(OP_JAL, 32'h0, 32'h0, 32'h40, 32'h700, 4'h9);
    @(negedge clk);
    hold = {1'b1, 4'h9, 32'h704, 1'b1, 32'h740};
    checks++;
    if (obs !== hold) begin errors++; $display("FAIL jal_before_hold: got %h want %h", obs, hold); end
    rdy = 1'b0; fetch_pc = 32'h600;
    drive(OP_BEQ, 32'd3, 32'd3, 32'h10, 32'h600, 4'hA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== hold) begin errors++; $display("FAIL rdy_hold_%0d: got %h want %h", i, obs, hold); end
    end
    checks++;
    if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL rdy_bht_frozen: got %b want 0", fetch_pred_taken); end
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_branches !== 32'd0 || stat_taken !== 32'd0)
      begin errors++; $display("FAIL rdy_stats_frozen: got %0d/%0d want 0/0", stat_branches, stat_taken); end
`endif
    rdy = 1'b1;
    drive(OP_BEQ, 32'd3, 32'd3, 32'h10, 32'h600, 4'hA);
    @(negedge clk);
    drive(OP_BNE, 32'd4, 32'd4, 32'h10, 32'h604, 4'hB);
    @(negedge clk);
    drive(OP_BLTU, 32'd1, 32'd2, 32'h10, 32'h608, 4'hC);
    @(negedge clk);
    in_valid = 1'b0; #1;
    checks++;
    if (fetch_pred_taken !== 1'b1) begin errors++; $display("FAIL resume_bht: got %b want 1", fetch_pred_taken); end
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_branches !== 32'd3 || stat_taken !== 32'd2)
      begin errors++; $display("FAIL stats_count: got %0d/%0d want 3/2", stat_branches, stat_taken); end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    op_bus_t     ops[8] = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR};
    logic [69:0] prev, want;
    logic [5:0]  op;
    logic [31:0] r1, r2, imm, pc;
    logic [3:0]  tag;
    logic        ep;
    exp_t        e;
    int          r;
    prev = '0;
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 8) ? ops[r] : ((r == 8) ? 6'h00 : 6'h3F);
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'(4 * $urandom_range(0, 7));
      tag = 4'($urandom);
      rdy = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 7) == 0);
      fetch_pc = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      ep = model_pred(fetch_pc);
      e = model(op, r1, r2, imm, pc);
      drive(op, r1, r2, imm, pc, tag);
      #1;
      checks++;
      if (fetch_pred_taken !== ep) begin errors++; $display("FAIL rand_pred_%0d: got %b want %b", n, fetch_pred_taken, ep); end
      if (!rdy) want = prev;
      else if (clear) want = '0;
      else want = {1'b1, tag, e.data, e.taken, e.target};
      @(negedge clk);
      checks++;
      if (obs !== want) begin errors++; $display("FAIL rand_out_%0d: got %h want %h", n, obs, want); end
      prev = want;
    end
    rdy = 1'b1; clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fetch_pc = 32'h1000 + 32'(4 * i); #1;
      checks++;
      if (fetch_pred_taken !== model_pred(fetch_pc))
        begin errors++; $display("FAIL rand_bht_%0d: got %b want %b", i, fetch_pred_taken, model_pred(fetch_pc)); end
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_branches !== 32'(m_br) || stat_taken !== 32'(m_tk))
      begin errors++; $display("FAIL rand_stats: got %0d/%0d want %0d/%0d", stat_branches, stat_taken, m_br, m_tk); end
`endif
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_bht();
    test_clear_reset();
    test_rdy_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
